// File: rtl/enemy_pkg.sv
// Shared state encoding, LFSR taps and screen constants for the enemy control slice.
package enemy_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPAWN,
      DRAW,
      WAIT_FRAME,
      ERASE,
      UPDATE,
      CHECK,
      DELAY
   } state_t;

   // Feedback taps at bits 7, 5, 4 and 3 (x^8 + x^6 + x^5 + x^4 + 1, maximal length).
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   localparam logic [2:0] COLOUR_BLACK = 3'b000;
   localparam logic [2:0] COLOUR_WHITE = 3'b111;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   // One left shift of the Fibonacci LFSR; the new bit 0 is the XOR of the tapped bits.
   function automatic logic [7:0] lfsr_step(input logic [7:0] value);
      return {value[6:0], ^(value & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/enemy_spawn_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used as the source of spawn randomness.
module lfsr8
   import enemy_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] state
);

   // Advance every clock; a nonzero seed keeps the register out of the all-zero lock-up state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SEED;
      end else begin
         state <= lfsr_step(state);
      end
   end

endmodule

// File: rtl/enemy_spawn_ctrl.sv
// Enemy control FSM: spawns an enemy with random attributes, sequences draw/erase
// with the plotter once per frame, and reports escapes and kills.
module enemy_spawn_ctrl
   import enemy_pkg::*;
#(
   parameter int         FRAME_TICKS        = 833333,
   parameter int         SPAWN_DELAY_FRAMES = 30,
   parameter int         X_MAX              = 150,
   parameter logic [7:0] LFSR_SEED          = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       hit,
   input  logic       drawDone,
   input  logic       bottomReached,
   output logic       inResetState,
   output logic       inUpdatePositionState,
   output logic       drawReq,
   output logic       eraseMode,
   output logic [7:0] enemyXIn,
   output logic [3:0] speedIn,
   output logic [2:0] colourIn,
   output logic       escaped,
   output logic       killed
);

   localparam int FW = $clog2(FRAME_TICKS);
   localparam int DW = $clog2(SPAWN_DELAY_FRAMES + 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
   localparam logic [DW-1:0] DELAY_LAST = DW'(SPAWN_DELAY_FRAMES - 1);

   state_t        state;
   state_t        next_state;

   logic [7:0]    lfsr_value;
   logic [7:0]    spawn_x;
   logic [3:0]    spawn_speed;
   logic [2:0]    spawn_colour;

   logic [FW-1:0] frame_cnt;
   logic [DW-1:0] delay_cnt;
   logic          counting;
   logic          frame_wrap;
   logic          delay_done;

   logic          hit_pending;
   logic          hit_window;
   logic          hit_accept;
   logic          escape_now;

   lfsr8 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .state (lfsr_value)
   );

   // Frame timing only runs in the two waiting states; a tick counts only while enabled,
   // so disabling the game parks the FSM with its counters frozen.
   assign counting   = (state == WAIT_FRAME) || (state == DELAY);
   assign frame_wrap = enable && (frame_cnt == FRAME_LAST);
   assign delay_done = frame_wrap && (delay_cnt == DELAY_LAST);

   // Hits count only while an enemy is alive on screen; a bottom decision in CHECK beats a same-cycle hit.
   assign escape_now = (state == CHECK) && bottomReached;
   assign hit_window = (state == DRAW) || (state == WAIT_FRAME) || (state == ERASE) ||
                       (state == UPDATE) || ((state == CHECK) && !bottomReached);
   assign hit_accept = hit && hit_window;

   // Map the raw LFSR value onto a legal spawn X, a speed of 1..4 and a visible colour.
   always_comb begin
      spawn_x      = lfsr_value;
      spawn_speed  = {2'b00, lfsr_value[1:0]} + 4'd1;
      spawn_colour = lfsr_value[4:2];
      if ({1'b0, lfsr_value} > 9'(X_MAX)) begin
         spawn_x = 8'({1'b0, lfsr_value} - 9'(X_MAX + 1));
      end
      if (lfsr_value[4:2] == COLOUR_BLACK) begin
         spawn_colour = COLOUR_WHITE;
      end
   end

   // State register; reset drops straight back to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic for the spawn / draw / move / erase loop.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (enable) begin
               next_state = SPAWN;
            end
         end
         SPAWN: begin
            next_state = DRAW;
         end
         DRAW: begin
            if (drawDone) begin
               next_state = WAIT_FRAME;
            end
         end
         WAIT_FRAME: begin
            if (frame_wrap) begin
               next_state = ERASE;
            end
         end
         ERASE: begin
            if (drawDone) begin
               next_state = (hit_pending || hit_accept) ? DELAY : UPDATE;
            end
         end
         UPDATE: begin
            next_state = CHECK;
         end
         CHECK: begin
            next_state = bottomReached ? DELAY : DRAW;
         end
         DELAY: begin
            if (delay_done) begin
               next_state = enable ? SPAWN : IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Moore strobes decoded straight from the state so they follow an async reset immediately.
   always_comb begin
      inResetState          = 1'b0;
      inUpdatePositionState = 1'b0;
      drawReq               = 1'b0;
      eraseMode             = 1'b0;
      case (state)
         IDLE, SPAWN, DELAY: begin
            inResetState = 1'b1;
         end
         UPDATE: begin
            inUpdatePositionState = 1'b1;
         end
         DRAW: begin
            drawReq = 1'b1;
         end
         ERASE: begin
            drawReq   = 1'b1;
            eraseMode = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Capture the enemy attributes from the LFSR during the single SPAWN cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enemyXIn <= 8'd0;
         speedIn  <= 4'd1;
         colourIn <= COLOUR_WHITE;
      end else if (state == SPAWN) begin
         enemyXIn <= spawn_x;
         speedIn  <= spawn_speed;
         colourIn <= spawn_colour;
      end
   end

   // Frame and delay counters; cleared whenever the FSM is outside the waiting states.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
         delay_cnt <= '0;
      end else if (!counting) begin
         frame_cnt <= '0;
         delay_cnt <= '0;
      end else if (enable) begin
         if (frame_wrap) begin
            frame_cnt <= '0;
            if (state == DELAY) begin
               delay_cnt <= delay_cnt + DW'(1);
            end
         end else begin
            frame_cnt <= frame_cnt + FW'(1);
         end
      end
   end

   // Latch the first hit on the current enemy and report it once; an escape discards it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_pending <= 1'b0;
         killed      <= 1'b0;
      end else begin
         killed <= hit_accept && !hit_pending;
         if ((state == SPAWN) || escape_now) begin
            hit_pending <= 1'b0;
         end else if (hit_accept) begin
            hit_pending <= 1'b1;
         end
      end
   end

   // One-cycle escape report when the enemy is seen at the bottom in CHECK.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         escaped <= 1'b0;
      end else begin
         escaped <= escape_now;
      end
   end

endmodule
